// File: rtl/exp_pkg.sv
// -----------------------------------------------------------------------------
// exp_pkg
// Shared definitions for the exp datapath: the range-reduction sequencer
// state encoding, the ln2 constant and the ln(1+2^-i) constant generator.
// The exp core imports the same package so both sides agree on the constants.
// No ports (package).
// -----------------------------------------------------------------------------
package exp_pkg;

    // Sequencer states: argument intake, integer (ln2) reduction, integer token
    // emission, one fraction step, fraction token emission.
    typedef enum logic [2:0] {
        IDLE,
        INT,
        EMIT_I,
        FRA,
        EMIT_F
    } seq_state_e;

    // ln2 at 11 fractional bits. It is deliberately 1419 rather than the
    // nearest-rounded 1420, and the exp core uses the same value.
    localparam int unsigned LN2_Q = 1419;

    // Internal precision used when building the ln(1+2^-i) table.
    localparam int unsigned LN_SERIES_P = 62;

    // round(ln(1 + 2^-i) * 2^frac_w), built from the alternating series
    // ln(1+y) = y - y^2/2 + y^3/3 - ... with y = 2^-i held at LN_SERIES_P bits.
    // Only ever evaluated at elaboration time to fill a constant table.
    function automatic int unsigned ln1p_q(input int unsigned i, input int unsigned frac_w);
        longint unsigned acc;
        longint unsigned term;
        acc = 64'd0;
        if (i == 0 || frac_w >= LN_SERIES_P) begin
            return 0;
        end
        for (int unsigned n = 1; n * i <= LN_SERIES_P; n++) begin
            term = (64'd1 << (LN_SERIES_P - n * i)) / 64'(n);
            if (n[0]) begin
                acc = acc + term;
            end else begin
                acc = acc - term;
            end
        end
        acc = (acc + (64'd1 << (LN_SERIES_P - frac_w - 1))) >> (LN_SERIES_P - frac_w);
        return 32'(acc);
    endfunction

endpackage

// File: rtl/exp_index_sequencer_if.sv
// -----------------------------------------------------------------------------
// exp_index_sequencer_if
// Bundles the argument intake stream and the token output stream of the
// exp range-reduction sequencer.
//   in_valid / in_ready / in_data      : argument stream (master -> slave)
//   out_valid / out_ready / out_*      : token stream (slave -> master)
// Modports:
//   slave  : the sequencer itself
//   master : the environment feeding arguments and consuming tokens
// -----------------------------------------------------------------------------
interface exp_index_sequencer_if #(
    parameter int DATA_W = 15,
    parameter int IDX_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_is_int;
    logic [IDX_W-1:0]  out_idx;
    logic              out_take;
    logic              out_last;
    logic [DATA_W-1:0] out_resid;
    logic              out_sat;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_is_int, out_idx, out_take,
               out_last, out_resid, out_sat
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_is_int, out_idx, out_take,
               out_last, out_resid, out_sat
    );
endinterface

// File: rtl/exp_ln_rom.sv
// -----------------------------------------------------------------------------
// exp_ln_rom
// Combinational constant table: ln1p = round(ln(1 + 2^-i) * 2^FRAC_W).
// Entries whose value rounds below one LSB (and i = 0) read as zero.
// Ports:
//   i     in   IDX_W   step index
//   ln1p  out  DATA_W  constant for step i
// -----------------------------------------------------------------------------
module exp_ln_rom
    import exp_pkg::*;
#(
    parameter int DATA_W = 15,
    parameter int FRAC_W = 11,
    parameter int IDX_W  = 5
) (
    input  logic [IDX_W-1:0]  i,
    output logic [DATA_W-1:0] ln1p
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [DATA_W-1:0] table_w [DEPTH];

    // Each entry is an elaboration-time constant, so this folds into plain logic.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        localparam logic [DATA_W-1:0] ENTRY = DATA_W'(ln1p_q(g, FRAC_W));
        assign table_w[g] = ENTRY;
    end

    assign ln1p = table_w[i];

endmodule

// File: rtl/exp_index_sequencer.sv
// -----------------------------------------------------------------------------
// exp_index_sequencer
// Iterative range reduction for the exp datapath. An accepted argument x is
// reduced by whole multiples of ln2 (count k, saturating at 2^IDX_W-1), then
// walked through i = 1..N_FRA, greedily subtracting ln(1+2^-i). One token is
// emitted per step on a valid/ready stream: the integer token first, then one
// fraction token per i, the last one flagged.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of exp_index_sequencer_if (argument in, tokens out)
// -----------------------------------------------------------------------------
module exp_index_sequencer
    import exp_pkg::*;
#(
    parameter int DATA_W = 15,
    parameter int FRAC_W = 11,
    parameter int IDX_W  = 5,
    parameter int N_FRA  = 11
) (
    input logic                  clk,
    input logic                  rst_n,
    exp_index_sequencer_if.slave bus
);

    localparam logic [DATA_W-1:0] LN2    = DATA_W'(LN2_Q);
    localparam logic [IDX_W-1:0]  K_MAX  = '1;
    localparam logic [IDX_W-1:0]  I_LAST = IDX_W'(N_FRA);

    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] resid_q, resid_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic [IDX_W-1:0]  i_q, i_d;

    logic              out_valid_q, out_valid_d;
    logic              out_is_int_q, out_is_int_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              out_take_q, out_take_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_resid_q, out_resid_d;
    logic              out_sat_q, out_sat_d;

    logic [DATA_W-1:0] ln1p_i;
    logic              ge_ln2;
    logic              frac_take;
    logic [DATA_W-1:0] frac_resid;
    logic              handshake;

    exp_ln_rom #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .IDX_W  (IDX_W)
    ) u_ln_rom (
        .i    (i_q),
        .ln1p (ln1p_i)
    );

    // Subtractions only ever happen behind their compare, so no underflow.
    // A zero table entry makes the step a "take" that leaves resid unchanged.
    assign ge_ln2     = (resid_q >= LN2);
    assign frac_take  = (resid_q >= ln1p_i);
    assign frac_resid = frac_take ? (resid_q - ln1p_i) : resid_q;
    assign handshake  = out_valid_q && bus.out_ready;

    // Next-state logic. Output fields are only reloaded when a new token is
    // formed, which keeps them frozen while a token waits for out_ready.
    always_comb begin
        state_d      = state_q;
        resid_d      = resid_q;
        k_d          = k_q;
        i_d          = i_q;
        out_valid_d  = out_valid_q;
        out_is_int_d = out_is_int_q;
        out_idx_d    = out_idx_q;
        out_take_d   = out_take_q;
        out_last_d   = out_last_q;
        out_resid_d  = out_resid_q;
        out_sat_d    = out_sat_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    resid_d = bus.in_data;
                    k_d     = '0;
                    state_d = INT;
                end
            end

            INT: begin
                if (ge_ln2 && (k_q != K_MAX)) begin
                    resid_d = resid_q - LN2;
                    k_d     = k_q + 1'b1;
                end else begin
                    // Reaching here with ge_ln2 still set means k ran out.
                    out_valid_d  = 1'b1;
                    out_is_int_d = 1'b1;
                    out_idx_d    = k_q;
                    out_take_d   = 1'b0;
                    out_last_d   = 1'b0;
                    out_resid_d  = resid_q;
                    out_sat_d    = ge_ln2;
                    state_d      = EMIT_I;
                end
            end

            EMIT_I: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    i_d         = IDX_W'(1);
                    state_d     = FRA;
                end
            end

            FRA: begin
                resid_d      = frac_resid;
                out_valid_d  = 1'b1;
                out_is_int_d = 1'b0;
                out_idx_d    = i_q;
                out_take_d   = frac_take;
                out_last_d   = (i_q == I_LAST);
                out_resid_d  = frac_resid;
                out_sat_d    = 1'b0;
                state_d      = EMIT_F;
            end

            EMIT_F: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = IDLE;
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = FRA;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, residual and the output register slice. Reset drops
    // any argument in flight, including a token waiting on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            resid_q      <= '0;
            k_q          <= '0;
            i_q          <= '0;
            out_valid_q  <= 1'b0;
            out_is_int_q <= 1'b0;
            out_idx_q    <= '0;
            out_take_q   <= 1'b0;
            out_last_q   <= 1'b0;
            out_resid_q  <= '0;
            out_sat_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            resid_q      <= resid_d;
            k_q          <= k_d;
            i_q          <= i_d;
            out_valid_q  <= out_valid_d;
            out_is_int_q <= out_is_int_d;
            out_idx_q    <= out_idx_d;
            out_take_q   <= out_take_d;
            out_last_q   <= out_last_d;
            out_resid_q  <= out_resid_d;
            out_sat_q    <= out_sat_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_is_int = out_is_int_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.out_take   = out_take_q;
    assign bus.out_last   = out_last_q;
    assign bus.out_resid  = out_resid_q;
    assign bus.out_sat    = out_sat_q;

endmodule
